// File: rtl/uart_ctrl_sched.sv
// Command scheduler: parses framed UART commands, queues up to four
// (ctrl_set, time_set) pairs and plays them back to the counter in order.
module uart_ctrl_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [7:0]  HEAD0   = 8'h55,
  parameter logic [7:0]  HEAD1   = 8'hA5,
  parameter logic [7:0]  TAIL    = 8'hF0,
  parameter logic [31:0] TIMEOUT = 32'd2_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        seq_done,
  output logic [7:0]  ctrl_set,
  output logic [31:0] time_set,
  output logic        cfg_load,
  output logic        busy,
  output logic [2:0]  fifo_count,
  output logic        frame_err,
  output logic        frame_drop
);

  typedef enum logic [2:0] {P_H0, P_H1, P_DATA, P_SUM, P_TAIL} pst_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} sst_t;

  pst_t        r_pst, w_pst_nxt;
  sst_t        r_sst, w_sst_nxt;
  logic [2:0]  r_idx;
  logic [39:0] r_pay;
  logic [7:0]  r_sum;
  logic [31:0] r_to_cnt;
  logic [39:0] r_mem [DEPTH];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_count;
  logic [7:0]  r_ctrl_set;
  logic [31:0] r_time_set;
  logic        r_frame_err, r_frame_drop;

  logic w_to, w_sum_bad, w_tail_bad, w_commit, w_abort, w_push_req;
  logic w_full, w_push, w_drop, w_pop;

  assign w_to       = !rx_done && (r_pst != P_H0) && (r_to_cnt == TIMEOUT - 32'd1);
  assign w_sum_bad  = rx_done && (r_pst == P_SUM) && (rx_data != r_sum);
  assign w_tail_bad = rx_done && (r_pst == P_TAIL) && (rx_data != TAIL);
  assign w_commit   = rx_done && (r_pst == P_TAIL) && (rx_data == TAIL);
  assign w_abort    = w_commit && (r_pay[7:0] == 8'h00);
  assign w_push_req = w_commit && !w_abort;
  assign w_full     = (r_count == 3'(DEPTH));
  assign w_push     = w_push_req && !w_full;
  assign w_drop     = w_push_req && w_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pst <= P_H0;
      r_sst <= S_IDLE;
    end else begin
      r_pst <= w_pst_nxt;
      r_sst <= w_sst_nxt;
    end
  end

  always_comb begin
    w_pst_nxt = r_pst;
    if (rx_done) begin
      unique case (r_pst)
        P_H0:    if (rx_data == HEAD0) w_pst_nxt = P_H1;
        P_H1:    if (rx_data == HEAD1) w_pst_nxt = P_DATA;
                 else if (rx_data != HEAD0) w_pst_nxt = P_H0;
        P_DATA:  if (r_idx == 3'd4) w_pst_nxt = P_SUM;
        P_SUM:   w_pst_nxt = w_sum_bad ? P_H0 : P_TAIL;
        P_TAIL:  w_pst_nxt = P_H0;
        default: w_pst_nxt = P_H0;
      endcase
    end else if (w_to) begin
      w_pst_nxt = P_H0;
    end
  end

  // Abort overrides any pop or seq_done decided in the same cycle.
  always_comb begin
    w_sst_nxt = r_sst;
    w_pop     = 1'b0;
    unique case (r_sst)
      S_IDLE: if (r_count != 3'd0) begin
                w_pop     = 1'b1;
                w_sst_nxt = S_LOAD;
              end
      S_LOAD: w_sst_nxt = S_RUN;
      S_RUN:  if (seq_done) begin
                if (r_count != 3'd0) begin
                  w_pop     = 1'b1;
                  w_sst_nxt = S_LOAD;
                end else begin
                  w_sst_nxt = S_IDLE;
                end
              end
      default: w_sst_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_pop     = 1'b0;
      w_sst_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx    <= '0;
      r_pay    <= '0;
      r_sum    <= '0;
      r_to_cnt <= '0;
    end else begin
      if (rx_done && (r_pst == P_H1) && (rx_data == HEAD1)) begin
        r_idx <= '0;
        r_sum <= '0;
      end else if (rx_done && (r_pst == P_DATA)) begin
        r_pay <= {r_pay[31:0], rx_data};
        r_sum <= r_sum ^ rx_data;
        r_idx <= r_idx + 3'd1;
      end
      if (rx_done || (r_pst == P_H0) || w_to) r_to_cnt <= '0;
      else                                    r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_pay;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ctrl_set   <= '0;
      r_time_set   <= '0;
      r_frame_err  <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_err  <= w_sum_bad || w_tail_bad || w_to;
      r_frame_drop <= w_drop;
      if (w_abort) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_ctrl_set <= '0;
        r_time_set <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 2'd1;
        if (w_pop) begin
          r_rptr     <= r_rptr + 2'd1;
          r_ctrl_set <= r_mem[r_rptr][7:0];
          r_time_set <= r_mem[r_rptr][39:8];
        end
        if (w_push && !w_pop)      r_count <= r_count + 3'd1;
        else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      end
    end
  end

  assign ctrl_set   = r_ctrl_set;
  assign time_set   = r_time_set;
  assign cfg_load   = (r_sst == S_LOAD);
  assign busy       = (r_sst != S_IDLE);
  assign fifo_count = r_count;
  assign frame_err  = r_frame_err;
  assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_uart_ctrl_sched.sv
// Directed bench for uart_ctrl_sched: every cfg_load is checked against a
// queue of expected {ctrl, time} pairs pushed as frames are sent.
module tb_uart_ctrl_sched;

  localparam logic [31:0] TO = 32'd16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        seq_done;
  logic [7:0]  ctrl_set;
  logic [31:0] time_set;
  logic        cfg_load;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        frame_err;
  logic        frame_drop;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_load = 0;
  int unsigned n_err  = 0;
  int unsigned n_drop = 0;
  logic [39:0] sb [$];

  uart_ctrl_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data),
    .seq_done(seq_done), .ctrl_set(ctrl_set), .time_set(time_set),
    .cfg_load(cfg_load), .busy(busy), .fifo_count(fifo_count),
    .frame_err(frame_err), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT produced.
  task automatic step();
    logic [39:0] e;
    @(negedge clk);
    if (cfg_load === 1'b1) begin
      n_load++;
      chk("load_expected", 40'(sb.size() != 0), 40'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("load_ctrl", 40'(ctrl_set), 40'(e[39:32]));
        chk("load_time", 40'(time_set), 40'(e[31:0]));
      end
    end
    if (frame_err === 1'b1)  n_err++;
    if (frame_drop === 1'b1) n_drop++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic send_frame(input logic [31:0] t, input logic [7:0] c, input logic [7:0] sum_flip);
    logic [7:0] s;
    s = t[31:24] ^ t[23:16] ^ t[15:8] ^ t[7:0] ^ c ^ sum_flip;
    send_byte(8'h55); send_byte(8'hA5);
    send_byte(t[31:24]); send_byte(t[23:16]); send_byte(t[15:8]); send_byte(t[7:0]);
    send_byte(c); send_byte(s); send_byte(8'hF0);
  endtask

  task automatic seq_pulse();
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    step();
  endtask

  initial begin
    int unsigned l0, e0, d0, k;
    reset_n = 1'b0; rx_done = 1'b0; rx_data = '0; seq_done = 1'b0;
    step(); step();
    chk("rst_ctrl", 40'(ctrl_set), 40'd0);
    chk("rst_time", 40'(time_set), 40'd0);
    chk("rst_load", 40'(cfg_load), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_count", 40'(fifo_count), 40'd0);
    chk("rst_err", 40'(frame_err), 40'd0);
    chk("rst_drop", 40'(frame_drop), 40'd0);
    reset_n = 1'b1;
    step();

    // Single frame, exact tail-to-load latency.
    sb.push_back({8'hA5, 32'd100});
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h64); send_byte(8'hA5); send_byte(8'hC1);
    rx_done = 1'b1; rx_data = 8'hF0;
    step();
    chk("t1_count", 40'(fifo_count), 40'd1);
    chk("t1_noload_early", 40'(cfg_load), 40'd0);
    rx_done = 1'b0;
    step();
    chk("t1_load", 40'(cfg_load), 40'd1);
    chk("t1_busy", 40'(busy), 40'd1);
    chk("t1_ctrl", 40'(ctrl_set), 40'hA5);
    chk("t1_time", 40'(time_set), 40'd100);
    step();
    chk("t1_load_pulse", 40'(cfg_load), 40'd0);

    // Bad checksum while running, then a good frame.
    l0 = n_load; e0 = n_err;
    send_frame(32'd100, 8'hA5, 8'h03);
    chk("t2_err", 40'(n_err - e0), 40'd1);
    chk("t2_count", 40'(fifo_count), 40'd0);
    chk("t2_noload", 40'(n_load - l0), 40'd0);
    sb.push_back({8'h3C, 32'h0000_1234});
    send_frame(32'h0000_1234, 8'h3C, 8'h00);
    chk("t2_queued", 40'(fifo_count), 40'd1);
    seq_pulse();
    chk("t2_load", 40'(n_load - l0), 40'd1);
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    chk("t2_idle", 40'(busy), 40'd0);
    step();

    // Five frames fill the FIFO behind the running entry; sixth is dropped.
    l0 = n_load; d0 = n_drop;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back({8'h10 + 8'(i), 32'h0001_0000 + 32'(i)});
      send_frame(32'h0001_0000 + 32'(i), 8'h10 + 8'(i), 8'h00);
    end
    chk("t3_full", 40'(fifo_count), 40'd4);
    chk("t3_drop", 40'(n_drop - d0), 40'd1);
    chk("t3_first_load", 40'(n_load - l0), 40'd1);
    for (int i = 0; i < 4; i++) seq_pulse();
    chk("t3_loads", 40'(n_load - l0), 40'd5);
    chk("t3_busy_last", 40'(busy), 40'd1);
    seq_pulse();
    chk("t3_idle", 40'(busy), 40'd0);
    chk("t3_empty", 40'(fifo_count), 40'd0);

    // Inter-byte timeout after a partial payload.
    e0 = n_err;
    send_byte(8'h55); send_byte(8'hA5);
    rx_done = 1'b1; rx_data = 8'h12;
    step();
    rx_done = 1'b0;
    k = 0;
    while (n_err == e0 && k < 4 * TO) begin
      step();
      k++;
    end
    chk("t4_err", 40'(n_err - e0), 40'd1);
    chk("t4_latency", 40'(k), 40'(TO));
    step();
    chk("t4_err_pulse", 40'(frame_err), 40'd0);
    l0 = n_load;
    sb.push_back({8'h77, 32'h0000_0200});
    send_frame(32'h0000_0200, 8'h77, 8'h00);
    chk("t4_after_load", 40'(n_load - l0), 40'd1);

    // Abort with one running and two queued.
    send_frame(32'h0000_0300, 8'h21, 8'h00);
    send_frame(32'h0000_0301, 8'h22, 8'h00);
    chk("t5_queued", 40'(fifo_count), 40'd2);
    l0 = n_load;
    send_frame(32'h1122_3344, 8'h00, 8'h00);
    chk("t5_count", 40'(fifo_count), 40'd0);
    chk("t5_busy", 40'(busy), 40'd0);
    chk("t5_ctrl", 40'(ctrl_set), 40'd0);
    chk("t5_time", 40'(time_set), 40'd0);
    chk("t5_noload", 40'(n_load - l0), 40'd0);
    seq_pulse(); step();
    chk("t5_seq_ignored", 40'(n_load - l0), 40'd0);
    chk("t5_still_idle", 40'(busy), 40'd0);

    // Reset mid-run with a queued entry and a partial frame in flight.
    sb.push_back({8'h44, 32'h0000_0400});
    send_frame(32'h0000_0400, 8'h44, 8'h00);
    send_frame(32'h0000_0401, 8'h45, 8'h00);
    send_byte(8'h55); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    chk("t6_pre_busy", 40'(busy), 40'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 40'(busy), 40'd0);
    chk("t6_rst_count", 40'(fifo_count), 40'd0);
    chk("t6_rst_ctrl", 40'(ctrl_set), 40'd0);
    chk("t6_rst_time", 40'(time_set), 40'd0);
    step(); step();
    reset_n = 1'b1;
    l0 = n_load; e0 = n_err;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h03 ^ 8'h04 ^ 8'h05); send_byte(8'hF0);
    chk("t6_tail_ignored", 40'(n_load - l0), 40'd0);
    chk("t6_no_err", 40'(n_err - e0), 40'd0);
    chk("t6_count", 40'(fifo_count), 40'd0);
    sb.push_back({8'h66, 32'hDEAD_BEEF});
    send_byte(8'h55);
    send_frame(32'hDEAD_BEEF, 8'h66, 8'h00);
    chk("t6_new_load", 40'(n_load - l0), 40'd1);
    chk("t6_busy", 40'(busy), 40'd1);

    chk("sb_drained", 40'(sb.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
